// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU issue stage of the NPC core:
//   - 4-bit ALU op codes (ALU_ADD .. ALU_EQ)
//   - RV32I major opcodes handled by the decoder
//   - issue_entry_t: one decoded instruction as held in the output registers
//   - funct3_to_op(): funct3 (+ alternate funct7 bit) to ALU op mapping
// Build option: ALU_ISSUE_BRANCH_EN adds the br_invert field to the entry.
// -----------------------------------------------------------------------------
package alu_pkg;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_NOT  = 4'b0010;
   localparam logic [3:0] ALU_AND  = 4'b0011;
   localparam logic [3:0] ALU_OR   = 4'b0100;
   localparam logic [3:0] ALU_XOR  = 4'b0101;
   localparam logic [3:0] ALU_SLT  = 4'b0110;
   localparam logic [3:0] ALU_SLTU = 4'b0111;
   localparam logic [3:0] ALU_SLL  = 4'b1000;
   localparam logic [3:0] ALU_SRL  = 4'b1001;
   localparam logic [3:0] ALU_SRA  = 4'b1010;
   localparam logic [3:0] ALU_EQ   = 4'b1011;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   typedef struct packed {
      logic [31:0] r1;
      logic [31:0] r2;
      logic [3:0]  sub;
      logic        alu_enable;
      logic [4:0]  rd;
      logic        wen;
      logic        illegal;
`ifdef ALU_ISSUE_BRANCH_EN
      logic        br_invert;
`endif
   } issue_entry_t;

   // alt selects the funct7=0100000 variant (SUB / SRA); it is ignored for
   // every other funct3, legality of funct7 is checked by the decoder.
   function automatic logic [3:0] funct3_to_op(input logic [2:0] f3, input logic alt);
      logic [3:0] op;
      case (f3)
         3'b000:  op = alt ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = alt ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/alu_issue_dec.sv
// -----------------------------------------------------------------------------
// alu_issue_dec
// Purely combinational RV32I ALU-class decoder.
// Ports:
//   inst      in  32  instruction word
//   pc        in  32  instruction PC (AUIPC operand)
//   rs1_data  in  32  register-file read data for rs1
//   rs2_data  in  32  register-file read data for rs2
//   entry     out     decoded issue entry
// Build option: ALU_ISSUE_BRANCH_EN enables BRANCH decode; otherwise BRANCH
// is treated as illegal.
// -----------------------------------------------------------------------------
module alu_issue_dec
   import alu_pkg::*;
(
   input  logic [31:0]  inst,
   input  logic [31:0]  pc,
   input  logic [31:0]  rs1_data,
   input  logic [31:0]  rs2_data,
   output issue_entry_t entry
);

   logic [6:0]  opcode;
   logic [6:0]  funct7;
   logic [2:0]  funct3;
   logic [4:0]  rd;
   logic [31:0] imm_i;
   logic [31:0] imm_u;
   logic        f7_zero;
   logic        f7_alt;
   logic        is_shift;
   logic        legal;
   logic        writes_rd;

   assign opcode   = inst[6:0];
   assign rd       = inst[11:7];
   assign funct3   = inst[14:12];
   assign funct7   = inst[31:25];
   assign imm_i    = {{20{inst[31]}}, inst[31:20]};
   assign imm_u    = {inst[31:12], 12'b0};
   assign f7_zero  = (funct7 == 7'b0000000);
   assign f7_alt   = (funct7 == 7'b0100000);
   assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

   always_comb begin
      entry     = '0;
      legal     = 1'b1;
      writes_rd = 1'b1;
      case (opcode)
         OPC_OP: begin
            entry.r1  = rs1_data;
            entry.r2  = rs2_data;
            entry.sub = funct3_to_op(funct3, f7_alt);
            // Only ADD/SUB and SRL/SRA have an alternate funct7 encoding.
            legal     = f7_zero || (f7_alt && ((funct3 == 3'b000) || (funct3 == 3'b101)));
         end
         OPC_OPIMM: begin
            entry.r1 = rs1_data;
            if (is_shift) begin
               entry.r2  = {27'b0, inst[24:20]};
               entry.sub = funct3_to_op(funct3, f7_alt);
               legal     = f7_zero || (f7_alt && (funct3 == 3'b101));
            end else begin
               // funct3 000 here is ADDI: the upper immediate bits are not funct7.
               entry.r2  = imm_i;
               entry.sub = funct3_to_op(funct3, 1'b0);
            end
         end
         OPC_LUI: begin
            entry.r2  = imm_u;
            entry.sub = ALU_ADD;
         end
         OPC_AUIPC: begin
            entry.r1  = pc;
            entry.r2  = imm_u;
            entry.sub = ALU_ADD;
         end
         OPC_BRANCH: begin
`ifdef ALU_ISSUE_BRANCH_EN
            entry.r1  = rs1_data;
            entry.r2  = rs2_data;
            writes_rd = 1'b0;
            // funct3[0] marks the negated form (BNE, BGE, BGEU).
            entry.br_invert = funct3[0];
            case (funct3[2:1])
               2'b00:   entry.sub = ALU_EQ;
               2'b10:   entry.sub = ALU_SLT;
               2'b11:   entry.sub = ALU_SLTU;
               default: legal     = 1'b0;
            endcase
`else
            legal = 1'b0;
`endif
         end
         default: legal = 1'b0;
      endcase

      if (!legal) begin
         entry         = '0;
         entry.illegal = 1'b1;
      end else begin
         entry.alu_enable = 1'b1;
         entry.rd         = writes_rd ? rd : 5'd0;
         entry.wen        = writes_rd && (rd != 5'd0);
      end
   end

endmodule

// File: rtl/alu_issue.sv
// -----------------------------------------------------------------------------
// alu_issue
// Decode/issue stage feeding the ALU operand interface. One instruction per
// cycle in over valid/ready, decoded, and presented from a registered output
// stage backed by a one-entry skid register so back-pressure never drops or
// reorders instructions.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   upstream handshake
//   in_inst, in_pc        instruction word and its PC
//   in_rs1_data/rs2_data  register-file read data
//   out_valid / out_ready execute handshake
//   out_r1, out_r2        ALU operands
//   out_sub               ALU op code
//   out_alu_enable        ALU performs the op
//   out_rd, out_wen       destination register and write enable
//   out_illegal           instruction not decodable here
//   out_br_invert         branch result inversion (only with ALU_ISSUE_BRANCH_EN)
// Build option: ALU_ISSUE_BRANCH_EN enables BRANCH decode and out_br_invert.
// -----------------------------------------------------------------------------
module alu_issue
   import alu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_inst,
   input  logic [XLEN-1:0] in_pc,
   input  logic [XLEN-1:0] in_rs1_data,
   input  logic [XLEN-1:0] in_rs2_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_r1,
   output logic [XLEN-1:0] out_r2,
   output logic [3:0]      out_sub,
   output logic            out_alu_enable,
   output logic [4:0]      out_rd,
   output logic            out_wen,
`ifdef ALU_ISSUE_BRANCH_EN
   output logic            out_br_invert,
`endif
   output logic            out_illegal
);

   issue_entry_t dec_entry;
   issue_entry_t main_reg;
   issue_entry_t skid_reg;
   issue_entry_t shown;
   logic         main_valid_reg;
   logic         skid_valid_reg;
   logic         ready_reg;
   logic         accept;
   logic         load_main;

   alu_issue_dec u_dec (
      .inst     (in_inst),
      .pc       (in_pc),
      .rs1_data (in_rs1_data),
      .rs2_data (in_rs2_data),
      .entry    (dec_entry)
   );

   // ready_reg mirrors !skid_valid_reg; it resets to 1 so the first cycle
   // after reset can accept, while rst itself forces every output low.
   assign in_ready  = ready_reg & ~rst;
   assign accept    = in_valid & in_ready;
   assign load_main = ~main_valid_reg | out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         main_valid_reg <= 1'b0;
         skid_valid_reg <= 1'b0;
         ready_reg      <= 1'b1;
         main_reg       <= '0;
         skid_reg       <= '0;
      end else if (load_main) begin
         if (skid_valid_reg) begin
            // in_ready is low while the skid is full, so no accept competes here.
            main_reg       <= skid_reg;
            main_valid_reg <= 1'b1;
            skid_valid_reg <= 1'b0;
            ready_reg      <= 1'b1;
         end else if (accept) begin
            main_reg       <= dec_entry;
            main_valid_reg <= 1'b1;
         end else begin
            main_valid_reg <= 1'b0;
         end
      end else if (accept) begin
         // Main is stalled: park the newcomer behind it.
         skid_reg       <= dec_entry;
         skid_valid_reg <= 1'b1;
         ready_reg      <= 1'b0;
      end
   end

   assign shown          = rst ? '0 : main_reg;
   assign out_valid      = main_valid_reg & ~rst;
   assign out_r1         = shown.r1;
   assign out_r2         = shown.r2;
   assign out_sub        = shown.sub;
   assign out_alu_enable = shown.alu_enable;
   assign out_rd         = shown.rd;
   assign out_wen        = shown.wen;
   assign out_illegal    = shown.illegal;
`ifdef ALU_ISSUE_BRANCH_EN
   assign out_br_invert  = shown.br_invert;
`endif

endmodule

// File: tb/tb_alu_issue.sv
// -----------------------------------------------------------------------------
// tb_alu_issue
// Directed steps followed by a randomized phase. Expected beats come from a
// specification-level decode model and an in-order queue of accepted
// instructions; the queue size also predicts out_valid and in_ready.
// Build option: ALU_ISSUE_BRANCH_EN selects the branch-enabled expectations.
// -----------------------------------------------------------------------------
module tb_alu_issue;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_inst;
   logic [31:0] in_pc;
   logic [31:0] in_rs1_data;
   logic [31:0] in_rs2_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_r1;
   logic [31:0] out_r2;
   logic [3:0]  out_sub;
   logic        out_alu_enable;
   logic [4:0]  out_rd;
   logic        out_wen;
   logic        out_illegal;
`ifdef ALU_ISSUE_BRANCH_EN
   logic        out_br_invert;
`endif

   always #5 clk = ~clk;

   alu_issue dut (
      .clk            (clk),
      .rst            (rst),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_inst        (in_inst),
      .in_pc          (in_pc),
      .in_rs1_data    (in_rs1_data),
      .in_rs2_data    (in_rs2_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_r1         (out_r1),
      .out_r2         (out_r2),
      .out_sub        (out_sub),
      .out_alu_enable (out_alu_enable),
      .out_rd         (out_rd),
      .out_wen        (out_wen),
`ifdef ALU_ISSUE_BRANCH_EN
      .out_br_invert  (out_br_invert),
`endif
      .out_illegal    (out_illegal)
   );

   typedef struct packed {
      logic [31:0] r1;
      logic [31:0] r2;
      logic [3:0]  sub;
      logic        en;
      logic [4:0]  rd;
      logic        wen;
      logic        ill;
      logic        inv;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;
   int   beats = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Decode straight from the instruction-set rules.
   function automatic exp_t model(input logic [31:0] inst, input logic [31:0] pc,
                                  input logic [31:0] a, input logic [31:0] b);
      exp_t       e;
      logic [3:0] base [8];
      logic [6:0] opc;
      logic [6:0] f7;
      logic [2:0] f3;
      bit         ok;
      bit         br;
      base = '{4'd0, 4'd8, 4'd6, 4'd7, 4'd5, 4'd9, 4'd4, 4'd3};
      opc = inst[6:0];
      f7  = inst[31:25];
      f3  = inst[14:12];
      ok  = 1;
      br  = 0;
      e   = '0;
      if (opc == 7'h33) begin
         e.r1 = a;
         e.r2 = b;
         if (f7 == 7'h00)                        e.sub = base[f3];
         else if (f7 == 7'h20 && f3 == 3'd0)     e.sub = 4'd1;
         else if (f7 == 7'h20 && f3 == 3'd5)     e.sub = 4'd10;
         else                                    ok = 0;
      end else if (opc == 7'h13) begin
         e.r1 = a;
         if (f3 == 3'd1 || f3 == 3'd5) begin
            e.r2 = {27'd0, inst[24:20]};
            if (f7 == 7'h00)                     e.sub = base[f3];
            else if (f7 == 7'h20 && f3 == 3'd5)  e.sub = 4'd10;
            else                                 ok = 0;
         end else begin
            e.r2  = {{20{inst[31]}}, inst[31:20]};
            e.sub = base[f3];
         end
      end else if (opc == 7'h37) begin
         e.r2 = {inst[31:12], 12'h000};
      end else if (opc == 7'h17) begin
         e.r1 = pc;
         e.r2 = {inst[31:12], 12'h000};
`ifdef ALU_ISSUE_BRANCH_EN
      end else if (opc == 7'h63) begin
         br   = 1;
         e.r1 = a;
         e.r2 = b;
         case (f3)
            3'd0: begin e.sub = 4'd11; e.inv = 0; end
            3'd1: begin e.sub = 4'd11; e.inv = 1; end
            3'd4: begin e.sub = 4'd6;  e.inv = 0; end
            3'd5: begin e.sub = 4'd6;  e.inv = 1; end
            3'd6: begin e.sub = 4'd7;  e.inv = 0; end
            3'd7: begin e.sub = 4'd7;  e.inv = 1; end
            default: ok = 0;
         endcase
`endif
      end else begin
         ok = 0;
      end
      if (!ok) begin
         e     = '0;
         e.ill = 1;
      end else begin
         e.en = 1;
         if (!br) begin
            e.rd  = inst[11:7];
            e.wen = (inst[11:7] != 5'd0);
         end
      end
      return e;
   endfunction

   function automatic logic [31:0] rand_inst();
      logic [31:0] w;
      int unsigned k;
      w = $urandom;
      k = $urandom_range(0, 9);
      case (k)
         0, 1, 2: begin
            w[6:0]   = 7'h33;
            w[31:25] = ($urandom_range(0, 3) == 0) ? 7'h20 : 7'h00;
         end
         3, 4: begin
            w[6:0] = 7'h13;
            if (w[14:12] == 3'd1 || w[14:12] == 3'd5)
               w[31:25] = ($urandom_range(0, 2) == 0) ? 7'h20 : 7'h00;
         end
         5: w[6:0] = 7'h37;
         6: w[6:0] = 7'h17;
         7: w[6:0] = 7'h63;
         8: w[6:0] = ($urandom_range(0, 1) == 0) ? 7'h33 : 7'h13;
         default: ;
      endcase
      if ($urandom_range(0, 7) == 0) w[11:7] = 5'd0;
      return w;
   endfunction

   task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] p,
                        input logic [31:0] a, input logic [31:0] b);
      in_valid    = v;
      in_inst     = i;
      in_pc       = p;
      in_rs1_data = a;
      in_rs2_data = b;
   endtask

   // Negedge sample: invariants, beat check against the queue head, then
   // bookkeeping of this cycle's drain and accept.
   task automatic sample();
      exp_t h;
      @(negedge clk);
      chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
      if (out_valid && q.size() > 0) begin
         h = q[0];
         chk("beat_r1", out_r1, h.r1);
         chk("beat_r2", out_r2, h.r2);
         chk("beat_sub", 32'(out_sub), 32'(h.sub));
         chk("beat_en", 32'(out_alu_enable), 32'(h.en));
         chk("beat_rd", 32'(out_rd), 32'(h.rd));
         chk("beat_wen", 32'(out_wen), 32'(h.wen));
         chk("beat_ill", 32'(out_illegal), 32'(h.ill));
`ifdef ALU_ISSUE_BRANCH_EN
         chk("beat_inv", 32'(out_br_invert), 32'(h.inv));
`endif
         if (out_ready) begin
            void'(q.pop_front());
            beats++;
            $display("beat %0d: sub=%0h r1=%h r2=%h rd=%0d wen=%0b ill=%0b",
                     beats, out_sub, out_r1, out_r2, out_rd, out_wen, out_illegal);
         end
      end
      if (in_valid && in_ready)
         q.push_back(model(in_inst, in_pc, in_rs1_data, in_rs2_data));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      out_ready = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);

      // Reset: everything low, including in_ready.
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_r1", out_r1, 32'd0);
      chk("rst_sub", 32'(out_sub), 32'd0);
      chk("rst_wen", 32'(out_wen), 32'd0);
      chk("rst_ill", 32'(out_illegal), 32'd0);
      tick();
      rst = 1'b0;
      out_ready = 1'b1;
      sample(); tick();

      // ADD x3,x1,x2
      drive(1'b1, 32'h002081B3, 32'h100, 32'd5, 32'd7);
      sample(); tick();
      in_valid = 1'b0;
      sample();
      chk("add_sub", 32'(out_sub), 32'd0);
      chk("add_r1", out_r1, 32'd5);
      chk("add_r2", out_r2, 32'd7);
      chk("add_rd", 32'(out_rd), 32'd3);
      chk("add_wen", 32'(out_wen), 32'd1);
      chk("add_en", 32'(out_alu_enable), 32'd1);
      tick();

      // SRAI x5,x6,4
      drive(1'b1, 32'h40435293, 32'h104, 32'hF000_0000, 32'h0);
      sample(); tick();
      in_valid = 1'b0;
      sample();
      chk("srai_sub", 32'(out_sub), 32'd10);
      chk("srai_r2", out_r2, 32'd4);
      chk("srai_rd", 32'(out_rd), 32'd5);
      tick();

      // LUI x1,0x12345
      drive(1'b1, 32'h123450B7, 32'h108, 32'hDEAD_BEEF, 32'h1);
      sample(); tick();
      in_valid = 1'b0;
      sample();
      chk("lui_sub", 32'(out_sub), 32'd0);
      chk("lui_r1", out_r1, 32'd0);
      chk("lui_r2", out_r2, 32'h1234_5000);
      tick();

      // All-zero word is illegal and issues exactly one beat.
      drive(1'b1, 32'h0, 32'h10C, 32'h5, 32'h6);
      sample(); tick();
      in_valid = 1'b0;
      sample();
      chk("ill_flag", 32'(out_illegal), 32'd1);
      chk("ill_en", 32'(out_alu_enable), 32'd0);
      chk("ill_wen", 32'(out_wen), 32'd0);
      chk("ill_r2", out_r2, 32'd0);
      tick();
      sample();
      chk("ill_one_beat", 32'(out_valid), 32'd0);
      tick();

      // BNE x1,x2,8
      drive(1'b1, 32'h00209463, 32'h110, 32'd1, 32'd2);
      sample(); tick();
      in_valid = 1'b0;
      sample();
`ifdef ALU_ISSUE_BRANCH_EN
      chk("bne_sub", 32'(out_sub), 32'd11);
      chk("bne_inv", 32'(out_br_invert), 32'd1);
      chk("bne_wen", 32'(out_wen), 32'd0);
      chk("bne_ill", 32'(out_illegal), 32'd0);
`else
      chk("bne_ill", 32'(out_illegal), 32'd1);
      chk("bne_en", 32'(out_alu_enable), 32'd0);
`endif
      tick();

      // Back-to-back ADD, SUB under a stall.
      out_ready = 1'b0;
      drive(1'b1, 32'h002081B3, 32'h200, 32'd5, 32'd7);
      sample(); tick();
      drive(1'b1, 32'h402081B3, 32'h204, 32'd9, 32'd4);
      sample(); tick();
      in_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         sample();
         chk("stall_in_ready", 32'(in_ready), 32'd0);
         chk("stall_hold_sub", 32'(out_sub), 32'd0);
         chk("stall_hold_r1", out_r1, 32'd5);
         tick();
      end
      out_ready = 1'b1;
      sample();
      chk("rel_first_sub", 32'(out_sub), 32'd0);
      tick();
      sample();
      chk("rel_second_valid", 32'(out_valid), 32'd1);
      chk("rel_second_sub", 32'(out_sub), 32'd1);
      chk("rel_second_r1", out_r1, 32'd9);
      tick();
      sample(); tick();

      // Reset with main and skid both full.
      out_ready = 1'b0;
      drive(1'b1, 32'h002081B3, 32'h300, 32'd1, 32'd1);
      sample(); tick();
      drive(1'b1, 32'h402081B3, 32'h304, 32'd2, 32'd2);
      sample(); tick();
      in_valid = 1'b0;
      sample();
      chk("pre_rst_full", 32'(q.size()), 32'd2);
      tick();
      rst = 1'b1;
      q.delete();
      @(negedge clk);
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_in_ready", 32'(in_ready), 32'd0);
      tick();
      rst = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         sample(); tick();
      end

      // Randomized traffic with random back-pressure.
      for (int i = 0; i < 600; i++) begin
         drive(1'b0, rand_inst(), $urandom, $urandom, $urandom);
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         sample(); tick();
      end

      // Drain whatever is left.
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         sample(); tick();
      end
      chk("final_empty", 32'(q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
